// File: rtl/cnt_pkg.sv
// Shared types for the parametrised up/down counter.
//   cnt_mode_e : CNT_SAT clamps at 0 / MAX_VAL, CNT_WRAP counts modulo MAX_VAL+1.
package cnt_pkg;

  typedef enum logic {
    CNT_SAT  = 1'b0,
    CNT_WRAP = 1'b1
  } cnt_mode_e;

endpackage

// File: rtl/cnt_step_calc.sv
// Combinational next-value calculator for one counting step.
// Ports:
//   i_cur    current count (always <= MAX_VAL)
//   i_up     1 = step up, 0 = step down
//   o_nxt    count after the step (saturated or wrapped per MODE)
//   o_evt    step crossed MAX_VAL (up) or 0 (down)
// All arithmetic is carried in WIDTH+1 bits so no WIDTH-bit wrap is ever relied on.
module cnt_step_calc
  import cnt_pkg::*;
#(
  parameter int        WIDTH   = 5,
  parameter int        MAX_VAL = (1 << WIDTH) - 1,
  parameter int        STEP    = 1,
  parameter cnt_mode_e MODE    = CNT_SAT
) (
  input  logic [WIDTH-1:0] i_cur,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_nxt,
  output logic             o_evt
);

  localparam logic [WIDTH:0] MAX_W  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] MOD_W  = (WIDTH+1)'(MAX_VAL + 1);

  logic [WIDTH:0] w_cur;
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_nxt;

  assign w_cur = {1'b0, i_cur};
  assign w_sum = w_cur + STEP_W;

  always_comb begin
    w_nxt = w_cur;
    o_evt = 1'b0;
    if (i_up) begin
      if (w_sum <= MAX_W) begin
        w_nxt = w_sum;
      end else begin
        o_evt = 1'b1;
        w_nxt = (MODE == CNT_SAT) ? MAX_W : (w_sum - MOD_W);
      end
    end else begin
      if (w_cur >= STEP_W) begin
        w_nxt = w_cur - STEP_W;
      end else begin
        o_evt = 1'b1;
        // cur < STEP <= MAX_VAL, so cur + MOD stays below 2**(WIDTH+1)
        w_nxt = (MODE == CNT_SAT) ? '0 : (w_cur + MOD_W - STEP_W);
      end
    end
  end

  assign o_nxt = w_nxt[WIDTH-1:0];

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down loop/index counter with saturate or wrap behaviour,
// parallel load and registered overflow/underflow pulses.
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   clr        synchronous clear of result and pulses
//   ld/ld_val  parallel load (value clamped to MAX_VAL)
//   cntU/cntD  count up/down by STEP (both high = hold)
//   result     registered count
//   down_done  result == 0
//   up_done    result == MAX_VAL
//   ovf/unf    one-cycle pulses aligned with the result the event produced
// Priority per edge: rst > clr > ld > (cntU & cntD) > cntU > cntD > hold.
module updown_counter_param
  import cnt_pkg::*;
#(
  parameter int        WIDTH   = 5,
  parameter int        MAX_VAL = (1 << WIDTH) - 1,
  parameter int        STEP    = 1,
  parameter cnt_mode_e MODE    = CNT_SAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             cntU,
  input  logic             cntD,
  output logic [WIDTH-1:0] result,
  output logic             down_done,
  output logic             up_done,
  output logic             ovf,
  output logic             unf
);

  if (MAX_VAL < 1 || MAX_VAL > (1 << WIDTH) - 1) begin : g_chk_max
    $error("updown_counter_param: MAX_VAL out of range 1..2**WIDTH-1");
  end
  if (STEP < 1 || STEP > MAX_VAL) begin : g_chk_step
    $error("updown_counter_param: STEP out of range 1..MAX_VAL");
  end

  localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_N = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] r_result;
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH-1:0] w_step_nxt;
  logic             w_step_evt;
  logic [WIDTH-1:0] w_ld_clamped;

  // Only one direction is ever applied per edge, so one calculator suffices;
  // when cntU is low the down result is used.
  cnt_step_calc #(
    .WIDTH  (WIDTH),
    .MAX_VAL(MAX_VAL),
    .STEP   (STEP),
    .MODE   (MODE)
  ) u_step (
    .i_cur(r_result),
    .i_up (cntU),
    .o_nxt(w_step_nxt),
    .o_evt(w_step_evt)
  );

  assign w_ld_clamped = ({1'b0, ld_val} > MAX_W) ? MAX_N : ld_val;

  always_ff @(posedge clk) begin
    r_ovf <= 1'b0;
    r_unf <= 1'b0;
    if (rst || clr) begin
      r_result <= '0;
    end else if (ld) begin
      r_result <= w_ld_clamped;
    end else if (cntU && cntD) begin
      r_result <= r_result;
    end else if (cntU) begin
      r_result <= w_step_nxt;
      r_ovf    <= w_step_evt;
    end else if (cntD) begin
      r_result <= w_step_nxt;
      r_unf    <= w_step_evt;
    end
  end

  assign result    = r_result;
  assign ovf       = r_ovf;
  assign unf       = r_unf;
  assign down_done = (r_result == '0);
  assign up_done   = (r_result == MAX_N);

endmodule

// File: tb/tb_updown_counter_param.sv
module tb_updown_counter_param;
  import cnt_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // SAT instance inputs/outputs
  logic       s_rst, s_clr, s_ld, s_u, s_d;
  logic [4:0] s_ld_val;
  logic [4:0] s_res;
  logic       s_dd, s_ud, s_ovf, s_unf;

  // WRAP instance inputs/outputs
  logic       w_rst, w_clr, w_ld, w_u, w_d;
  logic [4:0] w_ld_val;
  logic [4:0] w_res;
  logic       w_dd, w_ud, w_ovf, w_unf;

  int n_checks = 0;
  int n_errors = 0;

  updown_counter_param #(.WIDTH(5), .MAX_VAL(20), .STEP(3), .MODE(CNT_SAT)) u_sat (
    .clk(clk), .rst(s_rst), .clr(s_clr), .ld(s_ld), .ld_val(s_ld_val),
    .cntU(s_u), .cntD(s_d), .result(s_res), .down_done(s_dd), .up_done(s_ud),
    .ovf(s_ovf), .unf(s_unf)
  );

  updown_counter_param #(.WIDTH(5), .MAX_VAL(20), .STEP(3), .MODE(CNT_WRAP)) u_wrap (
    .clk(clk), .rst(w_rst), .clr(w_clr), .ld(w_ld), .ld_val(w_ld_val),
    .cntU(w_u), .cntD(w_d), .result(w_res), .down_done(w_dd), .up_done(w_ud),
    .ovf(w_ovf), .unf(w_unf)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // result, down_done, up_done, ovf, unf of the SAT instance
  task automatic chk_s(input string tag, input int r, input int dd, input int ud,
                       input int o, input int u);
    chk({tag, ".result"}, int'(s_res), r);
    chk({tag, ".down_done"}, int'(s_dd), dd);
    chk({tag, ".up_done"}, int'(s_ud), ud);
    chk({tag, ".ovf"}, int'(s_ovf), o);
    chk({tag, ".unf"}, int'(s_unf), u);
  endtask

  task automatic chk_w(input string tag, input int r, input int dd, input int ud,
                       input int o, input int u);
    chk({tag, ".result"}, int'(w_res), r);
    chk({tag, ".down_done"}, int'(w_dd), dd);
    chk({tag, ".up_done"}, int'(w_ud), ud);
    chk({tag, ".ovf"}, int'(w_ovf), o);
    chk({tag, ".unf"}, int'(w_unf), u);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int up_exp [7] = '{3, 6, 9, 12, 15, 18, 20};

  initial begin
    s_rst = 1'b0; s_clr = 1'b0; s_ld = 1'b0; s_u = 1'b0; s_d = 1'b0; s_ld_val = '0;
    w_rst = 1'b0; w_clr = 1'b0; w_ld = 1'b0; w_u = 1'b0; w_d = 1'b0; w_ld_val = '0;

    // reset with a count request also held
    s_rst = 1'b1; s_u = 1'b1;
    w_rst = 1'b1; w_d = 1'b1;
    tick();
    chk_s("reset_sat", 0, 1, 0, 0, 0);
    chk_w("reset_wrap", 0, 1, 0, 0, 0);
    s_rst = 1'b0; s_u = 1'b0;
    w_rst = 1'b0; w_d = 1'b0;

    // SAT down at 0: holds, unf pulses
    s_d = 1'b1; tick();
    chk_s("sat_down_at0", 0, 1, 0, 0, 1);
    s_d = 1'b0; s_u = 1'b1; tick();
    chk_s("sat_up_after0", 3, 0, 0, 0, 0);
    s_u = 1'b0;

    // clear back to 0, then 7 up steps
    s_clr = 1'b1; tick();
    chk_s("sat_clr", 0, 1, 0, 0, 0);
    s_clr = 1'b0;
    s_u = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_s($sformatf("sat_up%0d", i + 1), up_exp[i], 0, (i == 6) ? 1 : 0,
            (i == 6) ? 1 : 0, 0);
    end
    // held at MAX: back-to-back ovf pulses
    tick();
    chk_s("sat_hold_max1", 20, 0, 1, 1, 0);
    tick();
    chk_s("sat_hold_max2", 20, 0, 1, 1, 0);
    s_u = 1'b0; tick();
    chk_s("sat_idle", 20, 0, 1, 0, 0);

    // load, simultaneous up/down, clamped load, clr beats ld
    s_ld = 1'b1; s_ld_val = 5'd10; tick();
    chk_s("sat_ld10", 10, 0, 0, 0, 0);
    s_ld = 1'b0; s_u = 1'b1; s_d = 1'b1; tick();
    chk_s("sat_both", 10, 0, 0, 0, 0);
    s_u = 1'b0; s_d = 1'b0;
    s_ld = 1'b1; s_ld_val = 5'd31; tick();
    chk_s("sat_ld_clamp", 20, 0, 1, 0, 0);
    s_clr = 1'b1; s_ld_val = 5'd5; tick();
    chk_s("sat_clr_ld", 0, 1, 0, 0, 0);
    s_clr = 1'b0;
    s_ld_val = 5'd2; tick();
    chk_s("sat_ld2", 2, 0, 0, 0, 0);
    s_ld = 1'b0; s_d = 1'b1; tick();
    chk_s("sat_down_under", 0, 1, 0, 0, 1);
    s_d = 1'b0;

    // WRAP sequences
    w_ld = 1'b1; w_ld_val = 5'd19; tick();
    chk_w("wrap_ld19", 19, 0, 0, 0, 0);
    w_ld = 1'b0; w_u = 1'b1; tick();
    chk_w("wrap_up_ovf", 1, 0, 0, 1, 0);
    w_u = 1'b0; w_d = 1'b1; tick();
    chk_w("wrap_down_unf", 19, 0, 0, 0, 1);
    w_d = 1'b0; w_ld = 1'b1; w_ld_val = 5'd0; tick();
    chk_w("wrap_ld0", 0, 1, 0, 0, 0);
    w_ld = 1'b0; w_d = 1'b1; tick();
    chk_w("wrap_down0", 18, 0, 0, 0, 1);
    tick();
    chk_w("wrap_down18", 15, 0, 0, 0, 0);
    w_d = 1'b0; tick();
    chk_w("wrap_idle", 15, 0, 0, 0, 0);
    w_ld = 1'b1; w_ld_val = 5'd17; tick();
    chk_w("wrap_ld17", 17, 0, 0, 0, 0);
    w_ld = 1'b0; w_u = 1'b1; tick();
    chk_w("wrap_up20", 20, 0, 1, 0, 0);
    tick();
    chk_w("wrap_up_from20", 2, 0, 0, 1, 0);
    w_u = 1'b0;

    // rst while cntU held at 19
    w_ld = 1'b1; w_ld_val = 5'd19; tick();
    chk_w("wrap_ld19b", 19, 0, 0, 0, 0);
    w_ld = 1'b0; w_u = 1'b1; w_rst = 1'b1; tick();
    chk_w("wrap_rst_mid", 0, 1, 0, 0, 0);
    w_rst = 1'b0; w_u = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
